// File: rtl/spm_boot_loader.sv
// spm_boot_loader: flushes the SPM SRAM to FLUSH_VALUE after reset, loads program/data words
// from a valid/ready stream, then releases the RISC_SPM core reset.
// Optional feature: define LOADER_CKSUM_EN to add an XOR checksum check on the loaded stream;
// on a mismatch the core stays held and cksum_err is raised.
module spm_boot_loader #(
    parameter int unsigned WORD_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 8,
    parameter logic [WORD_SIZE-1:0] FLUSH_VALUE = '0,
    parameter int unsigned CNT_SIZE = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reload,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_SIZE-1:0] ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
`ifdef LOADER_CKSUM_EN
    input  logic [WORD_SIZE-1:0] exp_cksum,
    output logic                 cksum_err,
`endif
    output logic [CNT_SIZE-1:0]  word_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

    typedef enum logic [1:0] {StFlush, StLoad, StRun} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   flush_cnt_q, flush_cnt_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   ld_ready_q, ld_ready_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_SIZE-1:0]    word_count_q, word_count_d;
    logic                   handshake;
`ifdef LOADER_CKSUM_EN
    logic [WORD_SIZE-1:0]   cksum_q, cksum_d;
    logic                   cksum_bad_q, cksum_bad_d;
    logic                   cksum_err_q, cksum_err_d;
`endif

    // A word is accepted only while the registered ready is visible to the stream.
    assign handshake = ld_valid & ld_ready_q;

    // Next-state and registered-output logic for the flush/load/run sequence.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ld_ready_d   = 1'b0;
        cpu_rst_d    = cpu_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        word_count_d = word_count_q;
`ifdef LOADER_CKSUM_EN
        cksum_d      = cksum_q;
        cksum_bad_d  = cksum_bad_q;
        cksum_err_d  = cksum_err_q;
`endif
        unique case (state_q)
            StFlush: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = flush_cnt_q;
                mem_wdata_d = FLUSH_VALUE;
                flush_cnt_d = flush_cnt_q + ADDR_SIZE'(1);
                busy_d      = 1'b1;
                done_d      = 1'b0;
                cpu_rst_d   = 1'b0;
                if (flush_cnt_q == ADDR_SIZE'(DEPTH - 1)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ld_ready_d = 1'b1;
                if (handshake) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ld_addr;
                    mem_wdata_d = ld_data;
                    if (word_count_q != '1) begin
                        word_count_d = word_count_q + CNT_SIZE'(1);
                    end
`ifdef LOADER_CKSUM_EN
                    cksum_d = cksum_q ^ ld_data;
`endif
                    if (ld_last) begin
                        state_d    = StRun;
                        ld_ready_d = 1'b0;
`ifdef LOADER_CKSUM_EN
                        cksum_bad_d = ((cksum_q ^ ld_data) != exp_cksum);
`endif
                    end
                end
            end
            StRun: begin
                busy_d = 1'b0;
                done_d = 1'b1;
`ifdef LOADER_CKSUM_EN
                cpu_rst_d   = ~cksum_bad_q;
                cksum_err_d = cksum_bad_q;
`else
                cpu_rst_d = 1'b1;
`endif
                if (reload) begin
                    state_d      = StFlush;
                    flush_cnt_d  = '0;
                    cpu_rst_d    = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    word_count_d = '0;
`ifdef LOADER_CKSUM_EN
                    cksum_d     = '0;
                    cksum_bad_d = 1'b0;
                    cksum_err_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = StFlush;
            end
        endcase
    end

    // State and output registers; reset restarts the flush from address 0 at any time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StFlush;
            flush_cnt_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ld_ready_q   <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            word_count_q <= '0;
`ifdef LOADER_CKSUM_EN
            cksum_q      <= '0;
            cksum_bad_q  <= 1'b0;
            cksum_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ld_ready_q   <= ld_ready_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
`ifdef LOADER_CKSUM_EN
            cksum_q      <= cksum_d;
            cksum_bad_q  <= cksum_bad_d;
            cksum_err_q  <= cksum_err_d;
`endif
        end
    end

    assign ld_ready   = ld_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;
`ifdef LOADER_CKSUM_EN
    assign cksum_err  = cksum_err_q;
`endif

endmodule

// File: tb/tb_spm_boot_loader.sv
// Self-checking bench for spm_boot_loader: flush sweep, streamed loads with random gaps,
// reset mid-load, reload from RUN, word-count saturation and (if enabled) checksum checking.
module tb_spm_boot_loader;

    localparam int W      = 10;
    localparam int A      = 8;
    localparam int C      = 9;
    localparam int DEPTH  = 256;
    localparam int CNTMAX = 511;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         reload = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [A-1:0] ld_addr = '0;
    logic [W-1:0] ld_data = '0;
    logic         ld_last = 1'b0;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         cpu_rst;
    logic         busy;
    logic         done;
    logic [C-1:0] word_count;
`ifdef LOADER_CKSUM_EN
    logic [W-1:0] exp_cksum = '0;
    logic         cksum_err;
`endif

    int checks = 0;
    int failures = 0;

    // Words to stream in the next load.
    logic [A-1:0] waddr[$];
    logic [W-1:0] wdata[$];

    always #5 clk = ~clk;

    spm_boot_loader dut (
        .clk       (clk),
        .rst       (rst),
        .reload    (reload),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
`ifdef LOADER_CKSUM_EN
        .exp_cksum (exp_cksum),
        .cksum_err (cksum_err),
`endif
        .word_count(word_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem", {mem_we, mem_addr, mem_wdata}, 32'd0);
        check("rst_ctl", {ld_ready, cpu_rst, busy, done}, 32'b0010);
        check("rst_cnt", word_count, 32'd0);
`ifdef LOADER_CKSUM_EN
        check("rst_cksum_err", cksum_err, 32'd0);
`endif
    endtask

    // Expect DEPTH consecutive fill writes, then ready one cycle later. Stream and reload noise
    // is applied throughout and must be ignored.
    task automatic flush_seq();
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = A'($urandom);
            ld_data  = W'($urandom);
            reload   = 1'($urandom_range(0, 1));
            tick();
            check("flush_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, A'(i), W'(0)});
            check("flush_ctl", {ld_ready, cpu_rst, busy, done, word_count},
                  {4'b0010, C'(0)});
        end
        ld_valid = 1'($urandom_range(0, 1));
        reload   = 1'($urandom_range(0, 1));
        tick();
        check("flush_end", {mem_we, ld_ready, busy, cpu_rst, done}, 32'b01100);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'($urandom_range(0, 1));
            reload   = 1'($urandom_range(0, 1));
            tick();
            check_reset_outputs();
        end
        rst = 1'b1;
        flush_seq();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_ctl", {cpu_rst, done, busy, mem_we, ld_ready}, 32'b00100);
        check("reload_cnt", word_count, 32'd0);
`ifdef LOADER_CKSUM_EN
        check("reload_cksum_err", cksum_err, 32'd0);
`endif
        flush_seq();
    endtask

    // Stream waddr/wdata with random gaps; ready is expected high for the whole load phase.
    task automatic load_stream(input bit with_last, input bit exp_err);
        int  n = waddr.size();
        int  idx = 0;
        int  acc = 0;
        int  exp_cnt = 0;
        bit  hs;
        while (idx < n) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_addr  = waddr[idx];
            ld_data  = wdata[idx];
            ld_last  = with_last && (idx == n - 1);
            reload   = 1'($urandom_range(0, 1));
            hs       = ld_valid;
            tick();
            if (hs) begin
                check("ld_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, waddr[idx], wdata[idx]});
                acc++;
                idx++;
            end else begin
                check("ld_idle", mem_we, 32'd0);
            end
            exp_cnt = (acc > CNTMAX) ? CNTMAX : acc;
            check("ld_count", word_count, exp_cnt);
            check("ld_ready", ld_ready, !(hs && ld_last));
            check("ld_core_held", {cpu_rst, done, busy}, 32'b001);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        reload   = 1'b0;
        if (with_last) begin
            tick();
            check("run_ctl", {cpu_rst, done, busy, ld_ready, mem_we}, {!exp_err, 4'b1000});
`ifdef LOADER_CKSUM_EN
            check("run_cksum_err", cksum_err, exp_err);
`endif
            for (int i = 0; i < 3; i++) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_addr  = A'($urandom);
                tick();
                check("run_hold", {cpu_rst, done, busy, ld_ready, mem_we}, {!exp_err, 4'b1000});
                check("run_cnt", word_count, exp_cnt);
            end
            ld_valid = 1'b0;
        end
    endtask

    task automatic fill_random(input int n);
        waddr.delete();
        wdata.delete();
        for (int i = 0; i < n; i++) begin
            waddr.push_back(A'($urandom));
            wdata.push_back(W'($urandom));
        end
    endtask

    initial begin
        logic [A-1:0] prog_a[13] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                                     8'd8, 8'd9, 8'd10, 8'd112, 8'd113};
        logic [W-1:0] prog_d[13] = '{10'b11_0000_0001, 10'h111, 10'h222, 10'h0c3, 10'h3ff,
                                     10'h155, 10'h2aa, 10'h010, 10'h020, 10'h040,
                                     10'h080, 10'h002, 10'h005};

        // Reset flush.
        do_reset();

        // Program load of 13 words.
        waddr.delete();
        wdata.delete();
        for (int i = 0; i < 13; i++) begin
            waddr.push_back(prog_a[i]);
            wdata.push_back(prog_d[i]);
        end
        load_stream(1'b1, 1'b0);

        // Reload, then a random load with gaps and possible duplicate addresses.
        do_reload();
        fill_random(20);
        load_stream(1'b1, 1'b0);

        // Reset in the middle of a load.
        do_reload();
        fill_random(5);
        load_stream(1'b0, 1'b0);
        do_reset();

        // Single-word load.
        waddr.delete();
        wdata.delete();
        waddr.push_back(8'h0a);
        wdata.push_back(10'h1a5);
        load_stream(1'b1, 1'b0);

        // Long load to saturate the word counter.
        do_reload();
        fill_random(CNTMAX + 4);
        load_stream(1'b1, 1'b0);

`ifdef LOADER_CKSUM_EN
        // Matching checksum releases the core; mismatch keeps it held with cksum_err.
        do_reload();
        waddr.delete();
        wdata.delete();
        waddr.push_back(8'h00); wdata.push_back(10'h001);
        waddr.push_back(8'h01); wdata.push_back(10'h002);
        waddr.push_back(8'h02); wdata.push_back(10'h004);
        exp_cksum = 10'h007;
        load_stream(1'b1, 1'b0);
        do_reload();
        exp_cksum = 10'h006;
        load_stream(1'b1, 1'b1);
        do_reload();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
